// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 control sequencer: FSM states,
// major opcodes, ALU operation selects and trap cause codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } trap_cause_t;

  // Wide enough for any timeout limit up to 255 cycles.
  localparam int WAIT_W = 8;

  function automatic logic opcode_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the
// datapath plus memories (slave).
interface multicycle_ctrl_if
  import cpu_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
);

  // Handshakes: imem_req (resp. dmem_read/dmem_write) is held high until the
  // memory answers with imem_ready (resp. dmem_ready); the transfer happens in
  // the cycle where request and ready are both high, and the request drops (or
  // the FSM moves on) in the following cycle. ready outside a request is ignored.
  logic [6:0]         instr_opcode;
  logic               alu_zero;
  logic               imem_ready;
  logic               dmem_ready;

  logic               imem_req;
  logic               ir_write;
  logic               pc_write;
  logic               pc_src;
  logic               dmem_read;
  logic               dmem_write;
  logic               reg_write;
  logic               alu_src;
  logic               mem_to_reg;
  logic [1:0]         alu_op;

  logic               busy;
  logic               trap;
  logic [1:0]         trap_cause;
  logic [COUNT_W-1:0] instr_count;
  state_t             state;

  modport master (
    input  instr_opcode, alu_zero, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write,
           reg_write, alu_src, mem_to_reg, alu_op,
           busy, trap, trap_cause, instr_count, state
  );

  modport slave (
    output instr_opcode, alu_zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write,
           reg_write, alu_src, mem_to_reg, alu_op,
           busy, trap, trap_cause, instr_count, state
  );

endinterface

// File: rtl/wait_timer.sv
// Memory wait counter shared by FETCH and MEM: cleared on state entry, counts
// not-ready cycles and flags when the timeout limit has been reached.
module wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic limit_o
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer stepping each RV64 instruction through
// FETCH/DECODE/EXEC/MEM/WB with memory stall handling, traps and retire count.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  multicycle_ctrl_if.master  bus
);

  state_t             state_q, state_d;
  logic [6:0]         opcode_q, opcode_d;
  logic [COUNT_W-1:0] count_q, count_d;
  trap_cause_t        cause_q, cause_d;

  logic    wait_clear, wait_inc, wait_limit;
  logic    retire;
  logic    is_r, is_load, is_store;
  alu_op_t alu_op;

  assign is_r     = (opcode_q == OP_R);
  assign is_load  = (opcode_q == OP_LOAD);
  assign is_store = (opcode_q == OP_STORE);

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    count_d        = count_q;
    cause_d        = cause_q;
    retire         = 1'b0;
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 1'b0;
    alu_op         = ALU_ADD;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_write = 1'b1;
          state_d      = S_DECODE;
        end else if (wait_limit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        opcode_d = bus.instr_opcode;
        if (opcode_legal(bus.instr_opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (opcode_q)
          OP_R: begin
            alu_op  = ALU_FUNCT;
            state_d = S_WB;
          end
          OP_I: begin
            bus.alu_src = 1'b1;
            alu_op      = ALU_FUNCT;
            state_d     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            bus.alu_src = 1'b1;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            // Branch target comes from the unincremented PC, so retire here.
            alu_op       = ALU_SUB;
            bus.pc_write = 1'b1;
            bus.pc_src   = bus.alu_zero;
            retire       = 1'b1;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        bus.alu_src    = 1'b1;
        bus.dmem_read  = is_load;
        bus.dmem_write = is_store;
        if (bus.dmem_ready) begin
          if (is_store) begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_limit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = is_load;
        bus.alu_src    = !is_r;
        alu_op         = is_load ? ALU_ADD : ALU_FUNCT;
        bus.pc_write   = 1'b1;
        retire         = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // run is only honoured at the retirement boundary.
    if (retire) begin
      count_d = count_q + COUNT_W'(1);
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      count_q  <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
      cause_q  <= cause_d;
    end
  end

  assign wait_clear = ((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q);
  assign wait_inc   = ((state_q == S_FETCH) && !bus.imem_ready) ||
                      ((state_q == S_MEM) && !bus.dmem_ready);

  wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (reset),
    .clear_i(wait_clear),
    .inc_i  (wait_inc),
    .limit_o(wait_limit)
  );

  assign bus.alu_op      = alu_op;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign bus.trap        = (state_q == S_TRAP);
  assign bus.trap_cause  = cause_q;
  assign bus.instr_count = count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written
// corner sequences and randomized instruction streams against a cycle model.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int T  = 15;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;
  logic run;

  multicycle_ctrl_if #(.COUNT_W(CW)) bus ();

  multicycle_ctrl #(
    .MEM_TIMEOUT(T),
    .COUNT_W    (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       dmem_read;
    logic       dmem_write;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       busy;
    logic       trap;
    logic [1:0] cause;
  } outs_t;

  typedef struct packed {
    logic       ir;
    logic       dr;
    logic       z;
    logic       r;
    logic [6:0] op;
  } stim_t;

  typedef struct {
    logic [6:0] op;
    int         wi;
    int         wd;
    logic       z;
    int         lat;
    logic       regw;
    logic       mtr;
    logic       pcsrc;
    int         rd;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  stim_t          stim_q[$];
  logic [14:0]    exp_q[$];
  logic [CW-1:0]  cnt_exp_q[$];

  int          m_cnt;
  logic [1:0]  m_cause;
  bit          m_trap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.imem_req   = bus.imem_req;
    o.ir_write   = bus.ir_write;
    o.pc_write   = bus.pc_write;
    o.pc_src     = bus.pc_src;
    o.dmem_read  = bus.dmem_read;
    o.dmem_write = bus.dmem_write;
    o.reg_write  = bus.reg_write;
    o.alu_src    = bus.alu_src;
    o.mem_to_reg = bus.mem_to_reg;
    o.alu_op     = bus.alu_op;
    o.busy       = bus.busy;
    o.trap       = bus.trap;
    o.cause      = bus.trap_cause;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic do_reset(input bit chk);
    reset = 1'b0;
    run = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.instr_opcode = '0;
    bus.alu_zero = 1'b0;
    #1;
    if (chk) begin
      check("reset_outs", sample(), 64'd0);
      check("reset_count", bus.instr_count, 64'd0);
      check("reset_state", bus.state, S_IDLE);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle_cycle(input logic run_v);
    @(posedge clk);
    #1;
    run = run_v;
    @(negedge clk);
    check("idle_busy", bus.busy, 64'd0);
  endtask

  // Reactive memory environment: answers a request after a fixed wait and
  // measures instruction latency up to the retire strobe or a trap.
  task automatic exec_instr(input logic [6:0] op, input int wi, input int wd,
                            input logic z, input logic run_late,
                            output int lat, output logic trapped, output logic regw,
                            output logic mtr, output logic pcsrc, output int rd);
    int icnt, dcnt;
    icnt = 0; dcnt = 0; lat = 0; trapped = 0; regw = 0; mtr = 0; pcsrc = 0; rd = 0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      #1;
      run = (c <= 3) ? 1'b1 : run_late;
      bus.instr_opcode = op;
      bus.alu_zero = z;
      bus.imem_ready = bus.imem_req && (icnt == wi);
      bus.dmem_ready = (bus.dmem_read || bus.dmem_write) && (dcnt == wd);
      @(negedge clk);
      if (bus.imem_req) icnt++;
      if (bus.dmem_read || bus.dmem_write) dcnt++;
      if (bus.dmem_read) rd++;
      if (bus.reg_write) begin
        regw = 1'b1;
        mtr = bus.mem_to_reg;
      end
      if (bus.pc_write) begin
        pcsrc = bus.pc_src;
        lat = c;
        return;
      end
      if (bus.trap) begin
        trapped = 1'b1;
        lat = c;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL exec_budget: no retire or trap within 64 cycles, required one");
  endtask

  // ---------------- reference model: cycle schedule per instruction --------
  task automatic push(input logic ir, input logic dr, input logic [6:0] op,
                      input logic z, input logic r, input outs_t o);
    o.cause = m_cause;
    stim_q.push_back({ir, dr, z, r, op});
    exp_q.push_back(o);
    cnt_exp_q.push_back(CW'(m_cnt));
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) push(rb(), rb(), junk(), rb(), 1'b0, '0);
    push(rb(), rb(), junk(), rb(), 1'b1, '0);
  endtask

  task automatic go_trap(input logic [1:0] c);
    outs_t o;
    m_cause = c;
    m_trap = 1'b1;
    o = '0;
    o.trap = 1'b1;
    repeat (4) push(rb(), rb(), junk(), rb(), rb(), o);
  endtask

  task automatic retire_done(input logic run_end);
    m_cnt++;
    if (!run_end) idle_steps($urandom_range(0, 2));
  endtask

  task automatic plan_instr(input logic [6:0] op, input int wi, input int wd,
                            input logic z, input logic run_end);
    outs_t o;
    logic r, i, ld, st, br;
    r = (op == OP_R); i = (op == OP_I); ld = (op == OP_LOAD);
    st = (op == OP_STORE); br = (op == OP_BRANCH);
    // fetch: wait wi cycles; more than T waiting cycles traps
    for (int k = 0; k <= T; k++) begin
      o = '0; o.busy = 1'b1; o.imem_req = 1'b1;
      if (k == wi) begin
        o.ir_write = 1'b1;
        push(1'b1, rb(), junk(), rb(), rb(), o);
        break;
      end
      push(1'b0, rb(), junk(), rb(), rb(), o);
      if (k == T) begin
        go_trap(2'd2);
        return;
      end
    end
    o = '0; o.busy = 1'b1;
    push(rb(), rb(), op, rb(), rb(), o);
    if (!(r || i || ld || st || br)) begin
      go_trap(2'd1);
      return;
    end
    o = '0; o.busy = 1'b1;
    o.alu_src = !(r || br);
    o.alu_op = (r || i) ? 2'b10 : (br ? 2'b01 : 2'b00);
    if (br) begin
      o.pc_write = 1'b1; o.pc_src = z;
      push(rb(), rb(), junk(), z, run_end, o);
      retire_done(run_end);
      return;
    end
    push(rb(), rb(), junk(), rb(), rb(), o);
    if (ld || st) begin
      for (int k = 0; k <= T; k++) begin
        o = '0; o.busy = 1'b1; o.alu_src = 1'b1;
        o.dmem_read = ld; o.dmem_write = st;
        if (k == wd) begin
          if (st) begin
            o.pc_write = 1'b1;
            push(rb(), 1'b1, junk(), rb(), run_end, o);
            retire_done(run_end);
            return;
          end
          push(rb(), 1'b1, junk(), rb(), rb(), o);
          break;
        end
        push(rb(), 1'b0, junk(), rb(), rb(), o);
        if (k == T) begin
          go_trap(2'd3);
          return;
        end
      end
    end
    o = '0; o.busy = 1'b1; o.reg_write = 1'b1; o.mem_to_reg = ld;
    o.alu_src = !r; o.alu_op = ld ? 2'b00 : 2'b10; o.pc_write = 1'b1;
    push(rb(), rb(), junk(), rb(), run_end, o);
    retire_done(run_end);
  endtask

  task automatic drive_queue();
    stim_t s;
    logic [14:0] e;
    logic [CW-1:0] c;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      c = cnt_exp_q.pop_front();
      @(posedge clk);
      #1;
      bus.imem_ready = s.ir; bus.dmem_ready = s.dr; bus.alu_zero = s.z;
      run = s.r; bus.instr_opcode = s.op;
      @(negedge clk);
      check("rand_outs", sample(), e);
      check("rand_count", bus.instr_count, c);
    end
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 7) == 0) return $urandom_range(T - 1, T + 1);
    return $urandom_range(0, 3);
  endfunction

  function automatic logic [6:0] rand_op();
    int sel;
    sel = $urandom_range(0, 11);
    case (sel)
      0, 1:    return OP_R;
      2, 3:    return OP_I;
      4, 5:    return OP_LOAD;
      6, 7:    return OP_STORE;
      8, 9:    return OP_BRANCH;
      10:      return junk();
      default: return 7'h7F;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int lat, rd;
    logic trapped, regw, mtr, pcsrc;

    vecs[0] = '{OP_R,      0, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{OP_R,      0, 0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 0};
    vecs[2] = '{OP_I,      2, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{OP_LOAD,   0, 3, 1'b0, 8, 1'b1, 1'b1, 1'b0, 4};
    vecs[4] = '{OP_LOAD,   1, 0, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1};
    vecs[5] = '{OP_STORE,  0, 2, 1'b0, 6, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{OP_BRANCH, 0, 0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 0};
    vecs[7] = '{OP_BRANCH, 3, 0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 0};

    // directed table, back-to-back with run held high
    do_reset(1'b1);
    idle_cycle(1'b1);
    for (int v = 0; v < 8; v++) begin
      exec_instr(vecs[v].op, vecs[v].wi, vecs[v].wd, vecs[v].z, 1'b1,
                 lat, trapped, regw, mtr, pcsrc, rd);
      check("vec_latency", lat, vecs[v].lat);
      check("vec_trap", trapped, 64'd0);
      check("vec_reg_write", regw, vecs[v].regw);
      check("vec_mem_to_reg", mtr, vecs[v].mtr);
      check("vec_pc_src", pcsrc, vecs[v].pcsrc);
      check("vec_dmem_read_cycles", rd, vecs[v].rd);
      check("vec_count", bus.instr_count, v);
    end

    // illegal opcode traps after DECODE and holds through run toggles
    do_reset(1'b0);
    idle_cycle(1'b1);
    exec_instr(7'h7F, 0, 0, 1'b0, 1'b1, lat, trapped, regw, mtr, pcsrc, rd);
    check("illegal_latency", lat, 64'd3);
    check("illegal_trap", trapped, 64'd1);
    check("illegal_cause", bus.trap_cause, 64'd1);
    check("illegal_count", bus.instr_count, 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      run = ~run;
      bus.imem_ready = 1'b1;
      @(negedge clk);
      check("trap_hold", {bus.trap, bus.busy, bus.imem_req, bus.pc_write, bus.trap_cause},
            6'b100001);
    end

    // instruction fetch timeout
    do_reset(1'b0);
    idle_cycle(1'b1);
    exec_instr(OP_R, 100, 0, 1'b0, 1'b1, lat, trapped, regw, mtr, pcsrc, rd);
    check("imem_to_latency", lat, T + 2);
    check("imem_to_trap", trapped, 64'd1);
    check("imem_to_cause", bus.trap_cause, 64'd2);

    // ready in the limit cycle wins; one cycle later traps
    do_reset(1'b0);
    idle_cycle(1'b1);
    exec_instr(OP_R, T, 0, 1'b0, 1'b1, lat, trapped, regw, mtr, pcsrc, rd);
    check("limit_ready_latency", lat, T + 4);
    check("limit_ready_trap", trapped, 64'd0);
    do_reset(1'b0);
    idle_cycle(1'b1);
    exec_instr(OP_R, T + 1, 0, 1'b0, 1'b1, lat, trapped, regw, mtr, pcsrc, rd);
    check("limit_late_latency", lat, T + 2);
    check("limit_late_cause", bus.trap_cause, 64'd2);

    // data memory timeout
    do_reset(1'b0);
    idle_cycle(1'b1);
    exec_instr(OP_LOAD, 0, 100, 1'b0, 1'b1, lat, trapped, regw, mtr, pcsrc, rd);
    check("dmem_to_latency", lat, T + 5);
    check("dmem_to_cause", bus.trap_cause, 64'd3);
    check("dmem_to_no_regw", regw, 64'd0);

    // run dropped during a store wait: store completes, then idle
    do_reset(1'b0);
    idle_cycle(1'b1);
    exec_instr(OP_STORE, 0, 3, 1'b0, 1'b0, lat, trapped, regw, mtr, pcsrc, rd);
    check("store_stop_latency", lat, 64'd7);
    check("store_stop_regw", regw, 64'd0);
    for (int k = 0; k < 3; k++) begin
      idle_cycle(1'b0);
      check("store_stop_idle", {bus.imem_req, bus.state}, {1'b0, S_IDLE});
      check("store_stop_count", bus.instr_count, 64'd1);
    end

    // asynchronous reset in the middle of a load access
    do_reset(1'b0);
    idle_cycle(1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      bus.instr_opcode = OP_LOAD;
      bus.imem_ready = (k == 1);
      bus.dmem_ready = 1'b0;
      @(negedge clk);
    end
    check("mid_mem_read", bus.dmem_read, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_mem_reset_outs", sample(), 64'd0);
    check("mid_mem_reset_state", bus.state, S_IDLE);

    // randomized instruction streams against the cycle model
    for (int ep = 0; ep < 25; ep++) begin
      do_reset(1'b0);
      m_cnt = 0; m_cause = 2'd0; m_trap = 1'b0;
      idle_steps($urandom_range(0, 2));
      for (int n = 0; n < 6; n++) begin
        if (m_trap) break;
        plan_instr(rand_op(), rand_wait(), rand_wait(), rb(), rb());
      end
      drive_queue();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV64 datapath (PC, instruction memory, register file, ALU, data memory, write-back mux). It replaces the single-cycle combinational control and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Instruction and data memories may stall via ready handshakes. The block detects illegal opcodes and memory timeouts, counts retired instructions, and idles under a run control.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for imem_ready/dmem_ready before trapping (1..255)
COUNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  1 = execute instructions; 0 = stop at next retirement boundary
instr_opcode  in  7  instruction[6:0] from instruction register output
alu_zero  in  1  ALU zero flag (branch decision)
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register
pc_write  out  1  update PC (retire strobe)
pc_src  out  1  0 = PC+4, 1 = branch target
dmem_read  out  1  data memory read
dmem_write  out  1  data memory write
reg_write  out  1  register file write enable
alu_src  out  1  0 = rs2, 1 = immediate
mem_to_reg  out  1  1 = write-back from memory, 0 = from ALU
alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
busy  out  1  high in any state except IDLE and TRAP
trap  out  1  sticky error flag
trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
instr_count  out  COUNT_W  retired instruction count

Behaviour:
- Reset (reset=0, async): state=IDLE, opcode register=0, wait counter=0, instr_count=0, trap=0, trap_cause=0. All strobes 0 and alu_op=00 while in reset.
- Outputs are a combinational function of state, latched opcode, imem_ready/dmem_ready and alu_zero. Strobes not listed for a state are 0.
- IDLE: run=1 -> FETCH.
- FETCH: imem_req=1. On imem_ready=1, ir_write=1 in the same cycle -> DECODE.
- DECODE (1 cycle): latch instr_opcode.
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch.
  - Any other opcode -> TRAP with cause 1.
- EXEC (1 cycle):
  - R: alu_src=0, alu_op=10 -> WB.
  - I-ALU: alu_src=1, alu_op=10 -> WB.
  - Load/store: alu_src=1, alu_op=00 -> MEM.
  - Branch: alu_src=0, alu_op=01, pc_write=1, pc_src=alu_zero -> retire.
- MEM: alu_src=1, alu_op=00 held. dmem_read=1 (load) or dmem_write=1 (store) held until dmem_ready=1.
  - Load: on ready -> WB.
  - Store: on ready, pc_write=1, pc_src=0 -> retire.
- WB (1 cycle): reg_write=1, mem_to_reg=1 for load else 0, alu_src/alu_op held from EXEC, pc_write=1, pc_src=0 -> retire.
- Retire: instr_count increments (wraps modulo 2^COUNT_W) in the pc_write cycle. Next state is FETCH if run=1, else IDLE. run is sampled only at IDLE and at retirement; it never aborts an instruction.
- PC is written only at retirement, so the branch target is formed from the unincremented PC.
- Latency with zero-wait memory (ready asserted in the first request cycle): branch 3 cycles, R/I/store 4, load 5. Each wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle ready=0 in those states.
  - If it reaches MEM_TIMEOUT with ready still 0 -> TRAP, cause 2 (FETCH) or 3 (MEM).
  - ready arriving in the same cycle the limit is reached wins: no trap.
- TRAP: trap=1, all strobes 0, busy=0. Held until reset; run ignored.
- Reset mid-access drops all strobes immediately; no partial register or memory write is issued after reset asserts.

Decomposition:
- Package cpu_ctrl_pkg: state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP), opcode constants, alu_op encodings, trap_cause codes.
- Sub-module wait_timer: clear/enable/limit-reached counter parameterised by MEM_TIMEOUT, instantiated once and shared by FETCH and MEM.

Test Plan:
- Release reset with run=1, ready tied 1, opcode 0110011 -> ir_write at cycle 1, reg_write+pc_write at cycle 4, instr_count=1; repeat -> count 2 at cycle 8.
- Load 0000011 with dmem_ready delayed 3 cycles -> dmem_read high 4 cycles, then WB with mem_to_reg=1; total latency 8 cycles.
- Branch 1100011 with alu_zero=1 -> pc_write=1, pc_src=1 in EXEC (cycle 3); with alu_zero=0 -> pc_src=0; reg_write never asserts.
- Opcode 1111111 -> TRAP after DECODE; trap=1, trap_cause=1; no pc_write; state persists through run toggles until reset.
- imem_ready held 0 with MEM_TIMEOUT=15 -> trap_cause=2 after 15 wait cycles; second run asserts imem_ready exactly on cycle 15 -> no trap, DECODE follows.
- run dropped during a store's MEM wait -> store completes, pc_write, then IDLE with busy=0. Asserting reset low mid-MEM clears all outputs asynchronously.
